nandn_filt_xloop_xcontrol: RTL and testbench

//  Parametrised multi-channel NAND brick with registered, deglitched outputs: CHANNELS

---
 rtl/nandn_filt_xloop_xcontrol.sv | 75 +++++++
 tb/tb_nandn_filt_xloop_xcontrol.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/nandn_filt_xloop_xcontrol.sv
// Multi-channel NIN-input NAND brick with registered, deglitched outputs for control-loop paths.
// Each channel samples its NAND result, then moves o only after FILT stable cycles.
module nandn_filt_xloop_xcontrol #(
    parameter int NIN      = 2,
    parameter int CHANNELS = 4,
    parameter int FILT     = 3
) (
    input  logic                      CELCLK,
    input  logic                      CELRSTN,
    input  logic                      CELV,
    input  logic                      CELG,
    input  logic                      SUB,
    input  logic                      en,
    input  logic [CHANNELS*NIN-1:0]   i,
    output logic [CHANNELS-1:0]       o,
    output logic [CHANNELS-1:0]       chg,
    output logic [CHANNELS-1:0]       busy
);

    localparam int CW = (FILT > 0) ? (($clog2(FILT + 1) > 0) ? $clog2(FILT + 1) : 1) : 1;
    localparam int CNT_LAST_I = (FILT > 0) ? (FILT - 1) : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_I);

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] s1_reg;
    logic [CHANNELS-1:0] o_reg;
    logic [CHANNELS-1:0] chg_reg;
    logic [CW-1:0]       cnt_reg [CHANNELS];

    // Supply pins are kept only for interface compatibility with the older brick.
    logic unused_supply;
    assign unused_supply = ^{CELV, CELG, SUB};

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign raw[gi]  = ~&i[gi*NIN +: NIN];
        assign busy[gi] = s1_reg[gi] ^ o_reg[gi];
    end

    always_ff @(posedge CELCLK) begin
        if (!CELRSTN) begin
            s1_reg  <= '1;
            o_reg   <= '1;
            chg_reg <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_reg[c] <= '0;
            end
        end else begin
            s1_reg <= raw;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!en) begin
                    chg_reg[c] <= 1'b0;
                end else if (FILT == 0) begin
                    o_reg[c]   <= s1_reg[c];
                    chg_reg[c] <= s1_reg[c] ^ o_reg[c];
                    cnt_reg[c] <= '0;
                end else if (s1_reg[c] == o_reg[c]) begin
                    // A bounce back to the current level abandons any partial qualification.
                    cnt_reg[c] <= '0;
                    chg_reg[c] <= 1'b0;
                end else if (cnt_reg[c] == CNT_LAST) begin
                    o_reg[c]   <= s1_reg[c];
                    cnt_reg[c] <= '0;
                    chg_reg[c] <= 1'b1;
                end else begin
                    cnt_reg[c] <= cnt_reg[c] + CW'(1);
                    chg_reg[c] <= 1'b0;
                end
            end
        end
    end

    assign o   = o_reg;
    assign chg = chg_reg;

endmodule

// File: tb/tb_nandn_filt_xloop_xcontrol.sv
// Directed bench: filtered instance driven from a per-cycle vector table, bypass instance by hand.
module tb_nandn_filt_xloop_xcontrol;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       vdd = 1'b1;
    logic       gnd = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] i_main;
    logic [7:0] i_byp;
    logic [3:0] o_main, chg_main, busy_main;
    logic [3:0] o_byp, chg_byp, busy_byp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rstn;
        logic       en;
        logic [7:0] iv;
        logic [3:0] eo;
        logic [3:0] ec;
        logic [3:0] eb;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    nandn_filt_xloop_xcontrol #(.NIN(2), .CHANNELS(4), .FILT(3)) u_main (
        .CELCLK (clk),
        .CELRSTN(rstn),
        .CELV   (vdd),
        .CELG   (gnd),
        .SUB    (sub),
        .en     (en),
        .i      (i_main),
        .o      (o_main),
        .chg    (chg_main),
        .busy   (busy_main)
    );

    nandn_filt_xloop_xcontrol #(.NIN(2), .CHANNELS(4), .FILT(0)) u_byp (
        .CELCLK (clk),
        .CELRSTN(rstn),
        .CELV   (vdd),
        .CELG   (gnd),
        .SUB    (sub),
        .en     (en),
        .i      (i_byp),
        .o      (o_byp),
        .chg    (chg_byp),
        .busy   (busy_byp)
    );

    task automatic add(input logic r, input logic e, input logic [7:0] iv,
                       input logic [3:0] eo, input logic [3:0] ec, input logic [3:0] eb);
        vec_t v;
        v.rstn = r;
        v.en   = e;
        v.iv   = iv;
        v.eo   = eo;
        v.ec   = ec;
        v.eb   = eb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic bstep(input int row, input logic e, input logic [7:0] iv,
                         input logic [3:0] eo, input logic [3:0] ec, input logic [3:0] eb);
        @(negedge clk);
        en    = e;
        i_byp = iv;
        @(posedge clk);
        #1;
        $display("byp step %0d: en=%b i=%h o=%h chg=%h busy=%h", row, e, iv, o_byp, chg_byp, busy_byp);
        chk("byp_o", row, o_byp, eo);
        chk("byp_chg", row, chg_byp, ec);
        chk("byp_busy", row, busy_byp, eb);
    endtask

    initial begin
        rstn   = 1'b0;
        en     = 1'b1;
        i_main = 8'h00;
        i_byp  = 8'h00;

        // Reset with all raw=0, then idle.
        add(0, 1, 8'hFF, 4'hF, 4'h0, 4'h0);
        add(1, 1, 8'h00, 4'hF, 4'h0, 4'h0);
        // Latency on ch0: o falls on the 4th edge after the input change.
        add(1, 1, 8'h03, 4'hF, 4'h0, 4'h1);
        add(1, 1, 8'h03, 4'hF, 4'h0, 4'h1);
        add(1, 1, 8'h03, 4'hF, 4'h0, 4'h1);
        add(1, 1, 8'h03, 4'hE, 4'h1, 4'h0);
        add(1, 1, 8'h03, 4'hE, 4'h0, 4'h0);
        // Two-cycle glitch on ch1 is rejected.
        add(1, 1, 8'h0F, 4'hE, 4'h0, 4'h2);
        add(1, 1, 8'h0F, 4'hE, 4'h0, 4'h2);
        add(1, 1, 8'h03, 4'hE, 4'h0, 4'h0);
        add(1, 1, 8'h03, 4'hE, 4'h0, 4'h0);
        // ch0 back to 1: count to 1, freeze 5 cycles, resume.
        add(1, 1, 8'h00, 4'hE, 4'h0, 4'h1);
        add(1, 1, 8'h00, 4'hE, 4'h0, 4'h1);
        for (int k = 0; k < 5; k++) add(1, 0, 8'h00, 4'hE, 4'h0, 4'h1);
        add(1, 1, 8'h00, 4'hE, 4'h0, 4'h1);
        add(1, 1, 8'h00, 4'hF, 4'h1, 4'h0);
        add(1, 1, 8'h00, 4'hF, 4'h0, 4'h0);
        // ch2 reaches cnt=FILT-1, then reset discards it.
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(0, 1, 8'h30, 4'hF, 4'h0, 4'h0);
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(1, 1, 8'h30, 4'hF, 4'h0, 4'h4);
        add(1, 1, 8'h30, 4'hB, 4'h4, 4'h0);
        // ch1 and ch3 qualify together.
        add(1, 1, 8'hFC, 4'hB, 4'h0, 4'hA);
        add(1, 1, 8'hFC, 4'hB, 4'h0, 4'hA);
        add(1, 1, 8'hFC, 4'hB, 4'h0, 4'hA);
        add(1, 1, 8'hFC, 4'h1, 4'hA, 4'h0);
        add(1, 1, 8'hFC, 4'h1, 4'h0, 4'h0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rstn   = vecs[r].rstn;
            en     = vecs[r].en;
            i_main = vecs[r].iv;
            @(posedge clk);
            #1;
            $display("main step %0d: rstn=%b en=%b i=%h o=%h chg=%h busy=%h",
                     r, vecs[r].rstn, vecs[r].en, vecs[r].iv, o_main, chg_main, busy_main);
            chk("main_o", r, o_main, vecs[r].eo);
            chk("main_chg", r, chg_main, vecs[r].ec);
            chk("main_busy", r, busy_main, vecs[r].eb);
        end

        // Bypass instance: outputs follow s1 one edge later, all channels at once.
        bstep(0, 1'b1, 8'h00, 4'hF, 4'h0, 4'h0);
        bstep(1, 1'b1, 8'hFF, 4'hF, 4'h0, 4'hF);
        bstep(2, 1'b1, 8'hFF, 4'h0, 4'hF, 4'h0);
        bstep(3, 1'b1, 8'hFF, 4'h0, 4'h0, 4'h0);
        bstep(4, 1'b0, 8'h00, 4'h0, 4'h0, 4'hF);
        bstep(5, 1'b0, 8'h00, 4'h0, 4'h0, 4'hF);
        bstep(6, 1'b1, 8'h00, 4'hF, 4'hF, 4'h0);
        bstep(7, 1'b1, 8'h00, 4'hF, 4'h0, 4'h0);
        bstep(8, 1'b1, 8'h03, 4'hF, 4'h0, 4'h1);
        bstep(9, 1'b1, 8'h03, 4'hE, 4'h1, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
